dp_hpd_detector: RTL and testbench

// - Source-side Hot Plug Detect qualifier. Feeds link control and the AUX request logic.
// - Synchronises the sink's asynchronous HPD_Signal into clk_AUX and measures its high/low durations.
// - Classifies HPD activity into three events: plug, unplug and IRQ_HPD.
// - Provides a level connection status and a sticky IRQ flag with an acknowledge handshake.

---
 rtl/dp_hpd_detector.sv | 110 +++++++++++
 tb/tb_dp_hpd_detector.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dp_hpd_detector.sv
// Source-side Hot Plug Detect qualifier: synchronises the sink's HPD line into clk_AUX and
// classifies its activity into plug, unplug and IRQ_HPD events with a sticky IRQ flag.
module dp_hpd_detector #(
    parameter int unsigned CNT_W         = 18,
    parameter int unsigned GLITCH_CYCLES = 25000,
    parameter int unsigned UNPLUG_CYCLES = 200000,
    parameter int unsigned PLUG_CYCLES   = 200000
) (
    input  logic clk_AUX,
    input  logic rst_n,
    input  logic HPD_Signal,
    input  logic hpd_irq_ack,
    output logic hpd_connected,
    output logic hpd_plug,
    output logic hpd_unplug,
    output logic hpd_irq,
    output logic hpd_irq_pending
);

    localparam logic [CNT_W:0] GlitchThr = (CNT_W+1)'(GLITCH_CYCLES);
    localparam logic [CNT_W:0] UnplugThr = (CNT_W+1)'(UNPLUG_CYCLES);
    localparam logic [CNT_W:0] PlugThr   = (CNT_W+1)'(PLUG_CYCLES);

    typedef enum logic [1:0] {StDisc, StConn, StLow} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             hpd_meta;
    logic             hpd_s;
    logic [CNT_W:0]   cnt_inc;

    // One extra bit so the threshold compare can never alias on a wrapped count.
    assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

    always_ff @(posedge clk_AUX or negedge rst_n) begin
        if (!rst_n) begin
            hpd_meta <= 1'b0;
            hpd_s    <= 1'b0;
        end else begin
            hpd_meta <= HPD_Signal;
            hpd_s    <= hpd_meta;
        end
    end

    always_ff @(posedge clk_AUX or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StDisc;
            cnt_q           <= '0;
            hpd_connected   <= 1'b0;
            hpd_plug        <= 1'b0;
            hpd_unplug      <= 1'b0;
            hpd_irq         <= 1'b0;
            hpd_irq_pending <= 1'b0;
        end else begin
            hpd_plug   <= 1'b0;
            hpd_unplug <= 1'b0;
            hpd_irq    <= 1'b0;
            // Later assignments below (IRQ set, unplug clear) take precedence over the ack.
            if (hpd_irq_ack) hpd_irq_pending <= 1'b0;

            unique case (state_q)
                StDisc: begin
                    if (!hpd_s) begin
                        cnt_q <= '0;
                    end else if (cnt_inc == PlugThr) begin
                        state_q       <= StConn;
                        cnt_q         <= '0;
                        hpd_connected <= 1'b1;
                        hpd_plug      <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc[CNT_W-1:0];
                    end
                end
                StConn: begin
                    if (!hpd_s) begin
                        state_q <= StLow;
                        cnt_q   <= (CNT_W)'(1);
                    end else begin
                        cnt_q <= '0;
                    end
                end
                StLow: begin
                    if (!hpd_s) begin
                        if (cnt_inc == UnplugThr) begin
                            state_q         <= StDisc;
                            cnt_q           <= '0;
                            hpd_connected   <= 1'b0;
                            hpd_unplug      <= 1'b1;
                            hpd_irq_pending <= 1'b0;
                        end else begin
                            cnt_q <= cnt_inc[CNT_W-1:0];
                        end
                    end else begin
                        state_q <= StConn;
                        cnt_q   <= '0;
                        if ({1'b0, cnt_q} >= GlitchThr) begin
                            hpd_irq         <= 1'b1;
                            hpd_irq_pending <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StDisc;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dp_hpd_detector.sv
// Scoreboard bench for dp_hpd_detector: a run-length event model predicts every cycle's outputs,
// a monitor pops and compares them after each clock edge.
module tb_dp_hpd_detector;

    localparam int unsigned CNT_W  = 5;
    localparam int unsigned GLITCH = 4;
    localparam int unsigned UNPLUG = 20;
    localparam int unsigned PLUG   = 10;

    logic clk_AUX     = 1'b0;
    logic rst_n       = 1'b1;
    logic HPD_Signal  = 1'b0;
    logic hpd_irq_ack = 1'b0;
    logic hpd_connected, hpd_plug, hpd_unplug, hpd_irq, hpd_irq_pending;

    dp_hpd_detector #(
        .CNT_W        (CNT_W),
        .GLITCH_CYCLES(GLITCH),
        .UNPLUG_CYCLES(UNPLUG),
        .PLUG_CYCLES  (PLUG)
    ) dut (
        .clk_AUX        (clk_AUX),
        .rst_n          (rst_n),
        .HPD_Signal     (HPD_Signal),
        .hpd_irq_ack    (hpd_irq_ack),
        .hpd_connected  (hpd_connected),
        .hpd_plug       (hpd_plug),
        .hpd_unplug     (hpd_unplug),
        .hpd_irq        (hpd_irq),
        .hpd_irq_pending(hpd_irq_pending)
    );

    always #5 clk_AUX = ~clk_AUX;

    typedef struct packed {logic plug; logic unplug; logic irq; logic conn; logic pend;} exp_t;
    typedef struct packed {logic plug; logic unplug; logic irq;} ev_t;

    exp_t sb[$];
    ev_t  pipe[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   ack_cyc = -1;
    bit   done    = 1'b0;
    bit   rnd_ack = 1'b0;

    // Model state: link status as seen on the raw line, plus the lagged output levels.
    bit          m_conn, o_conn, o_pend;
    int unsigned m_hi, m_lo;

    task automatic model_reset();
        m_conn = 1'b0; o_conn = 1'b0; o_pend = 1'b0;
        m_hi   = 0;    m_lo   = 0;
        pipe.delete();
        sb.delete();
    endtask

    // One raw HPD cycle: an event completed by this sample shows up two edges later.
    task automatic step(input bit hpd);
        bit   ack;
        ev_t  e_new;
        ev_t  e_now;
        exp_t x;
        @(negedge clk_AUX);
        cyc++;
        ack = (cyc == ack_cyc) || (rnd_ack && $urandom_range(7) == 0);
        if (!rst_n) rst_n = 1'b1;
        HPD_Signal  = hpd;
        hpd_irq_ack = ack;

        e_new = '0;
        if (!m_conn) begin
            m_hi = hpd ? m_hi + 1 : 0;
            if (m_hi == PLUG) begin
                e_new.plug = 1'b1; m_conn = 1'b1; m_lo = 0;
            end
        end else if (!hpd) begin
            m_lo++;
            if (m_lo == UNPLUG) begin
                e_new.unplug = 1'b1; m_conn = 1'b0; m_hi = 0;
            end
        end else begin
            if (m_lo >= GLITCH) e_new.irq = 1'b1;
            m_lo = 0;
        end
        pipe.push_back(e_new);
        e_now = '0;
        if (pipe.size() > 2) e_now = pipe.pop_front();

        if (e_now.plug)   o_conn = 1'b1;
        if (e_now.unplug) o_conn = 1'b0;
        if (e_now.irq)                   o_pend = 1'b1;
        else if (e_now.unplug || ack)    o_pend = 1'b0;

        x.plug = e_now.plug; x.unplug = e_now.unplug; x.irq = e_now.irq;
        x.conn = o_conn;     x.pend   = o_pend;
        sb.push_back(x);
    endtask

    task automatic seg(input bit level, input int n);
        for (int i = 0; i < n; i++) step(level);
    endtask

    // Asynchronous assertion mid-cycle; release happens in the next step().
    task automatic reset_dut(input string tag);
        logic [4:0] got;
        @(posedge clk_AUX);
        #3;
        rst_n = 1'b0;
        #1;
        got = {hpd_plug, hpd_unplug, hpd_irq, hpd_connected, hpd_irq_pending};
        n_tests++;
        if (got !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_%s outputs p/u/i/c/pend got=%b required=00000", tag, got);
        end
        model_reset();
        repeat (3) @(posedge clk_AUX);
    endtask

    always begin
        exp_t x;
        exp_t got;
        @(posedge clk_AUX);
        #1;
        if (rst_n) begin
            got = {hpd_plug, hpd_unplug, hpd_irq, hpd_connected, hpd_irq_pending};
            if (sb.size() == 0) begin
                if (!done) begin
                    n_tests++; n_fail++;
                    $display("FAIL scoreboard_underflow cyc=%0d got=%b required=queued entry",
                             cyc, got);
                end
            end else begin
                x = sb.pop_front();
                n_tests++;
                if (got !== x) begin
                    n_fail++;
                    $display("FAIL outputs cyc=%0d p/u/i/c/pend got=%b required=%b", cyc, got, x);
                end
            end
        end
    end

    initial begin
        bit lvl;
        model_reset();
        #1 rst_n = 1'b0;
        reset_dut("initial");

        seg(1, 14);                              // plain plug

        reset_dut("before_bounce");
        seg(1, 6); seg(0, 1); seg(1, 14);        // bouncing plug

        seg(0, 3); seg(1, 5);                    // glitch
        seg(0, 8); seg(1, 5);                    // IRQ
        ack_cyc = cyc + 1;
        seg(1, 3);                               // ack clears pending
        seg(0, 6);
        ack_cyc = cyc + 3;                       // ack lands on the IRQ strobe edge
        seg(1, 5);

        seg(0, 25); seg(1, 14);                  // unplug with pending set, then replug

        seg(0, 6); seg(1, 4);                    // set pending again
        seg(0, 5);
        reset_dut("mid_irq");
        seg(1, 14);

        rnd_ack = 1'b1;
        lvl = 1'b0;
        for (int s = 0; s < 250; s++) begin
            seg(lvl, $urandom_range(1, 26));
            lvl = ~lvl;
        end

        @(posedge clk_AUX);
        #2;
        done = 1'b1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
